stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/clear/lap push-button front end and control FSM
// for a downstream stopwatch counter. Each button is synchronized,
// debounced, and edge-detected into a single-cycle press pulse.
// Define STOPWATCH_LAP_EN to build the lap button path and LAP state;
// without it i_btn_lap is ignored, LAP is unreachable and o_lap_hold is 0.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 1_250_000
) (
  input  logic       sysclk,
  input  logic       i_reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clr,
  input  logic       i_btn_lap,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_lap_hold,
  output logic [1:0] o_state
);

`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_t;

  // bit 0 = run, bit 1 = clear, bit 2 = lap (only when the lap path exists)
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync_a;
  logic [NB-1:0] sync_b;
  logic [NB-1:0] level;
  logic [NB-1:0] level_d;
  logic [NB-1:0] press;
  logic [CW-1:0] deb_cnt [NB];

  logic   run_press;
  logic   clr_press;
  logic   lap_press;
  state_t state;
  state_t state_next;
  logic   clear_next;

`ifdef STOPWATCH_LAP_EN
  assign btn_raw   = {i_btn_lap, i_btn_clr, i_btn_run};
  assign lap_press = press[2];
`else
  logic unused_lap;
  assign btn_raw    = {i_btn_clr, i_btn_run};
  assign unused_lap = i_btn_lap;
  assign lap_press  = 1'b0;
`endif
  assign run_press = press[0];
  assign clr_press = press[1];

  // Two-flop synchronizer for every raw button input
  always_ff @(posedge sysclk or posedge i_reset) begin
    if (i_reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Debounce: a level flips only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge sysclk or posedge i_reset) begin
    if (i_reset) begin
      level   <= '0;
      level_d <= '0;
      for (int i = 0; i < NB; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      level_d <= level;
      for (int i = 0; i < NB; i++) begin
        if (sync_b[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          level[i]   <= ~level[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // A press is the single cycle where a debounced level has just risen
  assign press = level & ~level_d;

  // Next-state decode: clr > run > lap, but a press the state ignores never blocks a lower one
  always_comb begin
    state_next = state;
    clear_next = 1'b0;
    case (state)
      IDLE: begin
        if (clr_press) begin
          clear_next = 1'b1;
        end else if (run_press) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (run_press) begin
          state_next = STOP;
        end else if (lap_press) begin
          state_next = LAP;
        end
      end
      STOP: begin
        if (clr_press) begin
          state_next = IDLE;
          clear_next = 1'b1;
        end else if (run_press) begin
          state_next = RUN;
        end
      end
      LAP: begin
        if (run_press) begin
          state_next = STOP;
        end else if (lap_press) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs move together on the edge after a press
  always_ff @(posedge sysclk or posedge i_reset) begin
    if (i_reset) begin
      state   <= IDLE;
      o_run   <= 1'b0;
      o_clear <= 1'b0;
    end else begin
      state   <= state_next;
      o_run   <= (state_next == RUN) || (state_next == LAP);
      o_clear <= clear_next;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Display freeze follows the LAP state, registered like the other outputs
  always_ff @(posedge sysclk or posedge i_reset) begin
    if (i_reset) begin
      o_lap_hold <= 1'b0;
    end else begin
      o_lap_hold <= (state_next == LAP);
    end
  end
`else
  assign o_lap_hold = 1'b0;
`endif

  assign o_state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus a randomized run against a
// history-window reference model of the debouncers and a transition table
// for the control FSM. Lap expectations follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int DEB = 4;

  logic       sysclk = 1'b0;
  logic       i_reset;
  logic       i_btn_run;
  logic       i_btn_clr;
  logic       i_btn_lap;
  logic       o_run;
  logic       o_clear;
  logic       o_lap_hold;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;

  stopwatch_ctrl #(.DEB_CYCLES(DEB)) dut (
    .sysclk    (sysclk),
    .i_reset   (i_reset),
    .i_btn_run (i_btn_run),
    .i_btn_clr (i_btn_clr),
    .i_btn_lap (i_btn_lap),
    .o_run     (o_run),
    .o_clear   (o_clear),
    .o_lap_hold(o_lap_hold),
    .o_state   (o_state)
  );

  always #5 sysclk = ~sysclk;

  // Reference model. Buttons indexed in priority order: 0=clr, 1=run, 2=lap.
  // States: 0=IDLE 1=RUN 2=STOP 3=LAP. -1 means the press is ignored there.
  int trans [4][3] = '{'{0, 1, -1}, '{-1, 2, 3}, '{0, 1, -1}, '{-1, 2, 1}};
  bit m_hist [3][6];
  bit m_lvl  [3];
  bit m_pend [3];
  bit m_raw  [3];
  int m_state;
  bit m_clear;
  bit m_acted;
  bit m_differ;

  // A level flips when the four samples seen through the 2-flop delay all differ from it
  always @(posedge sysclk or posedge i_reset) begin
    if (i_reset) begin
      for (int b = 0; b < 3; b++) begin
        for (int j = 0; j < 6; j++) m_hist[b][j] = 1'b0;
        m_lvl[b]  = 1'b0;
        m_pend[b] = 1'b0;
      end
      m_state = 0;
      m_clear = 1'b0;
    end else begin
      m_raw[0] = i_btn_clr;
      m_raw[1] = i_btn_run;
      m_raw[2] = LAP_EN ? i_btn_lap : 1'b0;
      m_clear  = 1'b0;
      m_acted  = 1'b0;
      for (int b = 0; b < 3; b++) begin
        if (!m_acted && m_pend[b] && trans[m_state][b] >= 0) begin
          m_acted = 1'b1;
          if (b == 0) m_clear = 1'b1;
          m_state = trans[m_state][b];
        end
      end
      for (int b = 0; b < 3; b++) begin
        for (int j = 0; j < 5; j++) m_hist[b][j] = m_hist[b][j+1];
        m_hist[b][5] = m_raw[b];
        m_differ = 1'b1;
        for (int j = 0; j < 4; j++) begin
          if (m_hist[b][j] == m_lvl[b]) m_differ = 1'b0;
        end
        m_pend[b] = 1'b0;
        if (m_differ) begin
          m_lvl[b]  = ~m_lvl[b];
          m_pend[b] = m_lvl[b];
        end
      end
    end
  end

  task automatic applyStimulus(input logic run, input logic clr, input logic lap);
    i_btn_run = run;
    i_btn_clr = clr;
    i_btn_lap = lap;
  endtask

  task automatic press_btns(input logic run, input logic clr, input logic lap);
    applyStimulus(run, clr, lap);
    repeat (8) @(negedge sysclk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge sysclk);
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge sysclk);
    total++; if (o_state !== 2'b00) begin bad++; $display("[TB] FAIL reset_state got=%b want=00", o_state); end
    total++; if (o_run !== 1'b0) begin bad++; $display("[TB] FAIL reset_run got=%b want=0", o_run); end
    total++; if (o_clear !== 1'b0) begin bad++; $display("[TB] FAIL reset_clear got=%b want=0", o_clear); end
    total++; if (o_lap_hold !== 1'b0) begin bad++; $display("[TB] FAIL reset_hold got=%b want=0", o_lap_hold); end
    i_reset = 1'b0;
    repeat (2) @(negedge sysclk);
    total++; if (o_state !== 2'b00) begin bad++; $display("[TB] FAIL post_reset_state got=%b want=00", o_state); end
  endtask

  task automatic test_run_latency();
    logic [1:0] prev;
    int changes;
    prev    = o_state;
    changes = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge sysclk);
      if (o_state !== prev) changes++;
      prev = o_state;
      if (i == 6) begin
        total++; if (o_state !== 2'b00) begin bad++; $display("[TB] FAIL latency_early_state got=%b want=00", o_state); end
      end
      if (i == 7) begin
        total++; if (o_state !== 2'b01) begin bad++; $display("[TB] FAIL latency_state got=%b want=01", o_state); end
        total++; if (o_run !== 1'b1) begin bad++; $display("[TB] FAIL latency_run got=%b want=1", o_run); end
      end
    end
    total++; if (changes !== 1) begin bad++; $display("[TB] FAIL held_run_transitions got=%0d want=1", changes); end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge sysclk);
  endtask

  task automatic test_glitch();
    int changes;
    changes = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge sysclk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      @(negedge sysclk);
      if (o_state !== 2'b01 || o_run !== 1'b1) changes++;
    end
    total++; if (changes !== 0) begin bad++; $display("[TB] FAIL glitch_disturbed got=%0d want=0", changes); end
    total++; if (o_state !== 2'b01) begin bad++; $display("[TB] FAIL glitch_state got=%b want=01", o_state); end
  endtask

  task automatic test_lap();
    logic [1:0] exp_state;
    exp_state = LAP_EN ? 2'b11 : 2'b01;
    press_btns(1'b0, 1'b0, 1'b1);
    total++; if (o_state !== exp_state) begin bad++; $display("[TB] FAIL lap_state got=%b want=%b", o_state, exp_state); end
    total++; if (o_run !== 1'b1) begin bad++; $display("[TB] FAIL lap_run got=%b want=1", o_run); end
    total++; if (o_lap_hold !== LAP_EN) begin bad++; $display("[TB] FAIL lap_hold got=%b want=%b", o_lap_hold, LAP_EN); end
    press_btns(1'b0, 1'b0, 1'b1);
    total++; if (o_state !== 2'b01) begin bad++; $display("[TB] FAIL lap_return_state got=%b want=01", o_state); end
    total++; if (o_lap_hold !== 1'b0) begin bad++; $display("[TB] FAIL lap_return_hold got=%b want=0", o_lap_hold); end
  endtask

  task automatic test_back_to_back();
    int clears;
    int consec;
    logic prev;
    press_btns(1'b1, 1'b0, 1'b0);
    total++; if (o_state !== 2'b10) begin bad++; $display("[TB] FAIL stop_state got=%b want=10", o_state); end
    total++; if (o_run !== 1'b0) begin bad++; $display("[TB] FAIL stop_run got=%b want=0", o_run); end
    clears = 0;
    consec = 0;
    prev   = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge sysclk);
      if (i == 8) applyStimulus(1'b0, 1'b0, 1'b0);
      if (o_clear === 1'b1) clears++;
      if (o_clear === 1'b1 && prev) consec++;
      prev = o_clear;
      if (i == 7) begin
        total++; if (o_clear !== 1'b1) begin bad++; $display("[TB] FAIL clr_pulse_edge got=%b want=1", o_clear); end
      end
    end
    total++; if (clears !== 1) begin bad++; $display("[TB] FAIL clr_pulse_count got=%0d want=1", clears); end
    total++; if (consec !== 0) begin bad++; $display("[TB] FAIL clr_consecutive got=%0d want=0", consec); end
    total++; if (o_state !== 2'b00) begin bad++; $display("[TB] FAIL clr_state got=%b want=00", o_state); end
    total++; if (o_run !== 1'b0) begin bad++; $display("[TB] FAIL clr_run got=%b want=0", o_run); end
    clears = 0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge sysclk);
      if (i == 8) applyStimulus(1'b0, 1'b0, 1'b0);
      if (o_clear === 1'b1) clears++;
    end
    total++; if (clears !== 1) begin bad++; $display("[TB] FAIL idle_clr_count got=%0d want=1", clears); end
    total++; if (o_state !== 2'b00) begin bad++; $display("[TB] FAIL idle_clr_state got=%b want=00", o_state); end
  endtask

  task automatic test_reset_mid_debounce();
    press_btns(1'b1, 1'b0, 1'b0);
    press_btns(1'b1, 1'b0, 1'b0);
    total++; if (o_state !== 2'b10) begin bad++; $display("[TB] FAIL mid_pre_state got=%b want=10", o_state); end
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge sysclk);
    #2 i_reset = 1'b1;
    #1;
    total++; if (o_state !== 2'b00) begin bad++; $display("[TB] FAIL async_reset_state got=%b want=00", o_state); end
    total++; if (o_run !== 1'b0 || o_clear !== 1'b0 || o_lap_hold !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset_outs got=%b%b%b want=000", o_run, o_clear, o_lap_hold);
    end
    repeat (2) @(negedge sysclk);
    i_reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge sysclk);
      if (i == 6) begin
        total++; if (o_state !== 2'b00) begin bad++; $display("[TB] FAIL redebounce_early got=%b want=00", o_state); end
      end
      if (i == 7) begin
        total++; if (o_state !== 2'b01) begin bad++; $display("[TB] FAIL redebounce_state got=%b want=01", o_state); end
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge sysclk);
  endtask

  task automatic test_random();
    logic r;
    logic c;
    logic l;
    logic [1:0] exp_state;
    logic exp_run;
    logic exp_hold;
    r = 1'b0; c = 1'b0; l = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge sysclk);
      exp_state = m_state[1:0];
      exp_run   = (m_state == 1) || (m_state == 3);
      exp_hold  = (m_state == 3);
      total++; if (o_state !== exp_state) begin bad++; $display("[TB] FAIL rand_state cyc=%0d got=%b want=%b", i, o_state, exp_state); end
      total++; if (o_run !== exp_run) begin bad++; $display("[TB] FAIL rand_run cyc=%0d got=%b want=%b", i, o_run, exp_run); end
      total++; if (o_lap_hold !== exp_hold) begin bad++; $display("[TB] FAIL rand_hold cyc=%0d got=%b want=%b", i, o_lap_hold, exp_hold); end
      total++; if (o_clear !== m_clear) begin bad++; $display("[TB] FAIL rand_clear cyc=%0d got=%b want=%b", i, o_clear, m_clear); end
      if ($urandom_range(0, 4) == 0) r = ~r;
      if ($urandom_range(0, 6) == 0) c = ~c;
      if ($urandom_range(0, 4) == 0) l = ~l;
      applyStimulus(r, c, l);
      i_reset = ($urandom_range(0, 249) == 0);
    end
    i_reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] stopwatch_ctrl bench, lap feature=%0d", LAP_EN);
    test_reset();
    test_run_latency();
    test_glitch();
    test_lap();
    test_back_to_back();
    test_reset_mid_debounce();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
